alu_pipe: RTL and testbench

ALU_PIPE -- requirements
Module: alu_pipe

---
 rtl/alu_pipe_if.sv | 42 ++++
 rtl/alu_pipe.sv | 242 ++++++++++++++++++++++++
 tb/tb_alu_pipe.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_pipe_if.sv
// rtl/alu_pipe_if.sv - request/response bundle for the pipelined ALU
//
// Purpose: groups the operation request, the result handshake and the
//          registered result/flags of alu_pipe into one bundle.
// Signals:
//   in_valid, in_ready        request handshake
//   mode, dec, alu_a, alu_b,
//   carry_in                  operation fields, sampled on acceptance
//   out_valid, out_ready      result handshake
//   alu_out, carry_out,
//   overflow, zero, sign      registered result and flags
// Modports:
//   master  requester / consumer side
//   slave   ALU side
interface alu_pipe_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [2:0]       mode;
   logic             dec;
   logic [WIDTH-1:0] alu_a;
   logic [WIDTH-1:0] alu_b;
   logic             carry_in;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] alu_out;
   logic             carry_out;
   logic             overflow;
   logic             zero;
   logic             sign;

   modport master (
      output in_valid, mode, dec, alu_a, alu_b, carry_in, out_ready,
      input  in_ready, out_valid, alu_out, carry_out, overflow, zero, sign
   );

   modport slave (
      input  in_valid, mode, dec, alu_a, alu_b, carry_in, out_ready,
      output in_ready, out_valid, alu_out, carry_out, overflow, zero, sign
   );
endinterface

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - handshaked ALU with registered result and flags
//
// Purpose: accepts one operation per cycle, delivers a registered result
//          with C/V/Z/N flags one cycle later. Decimal ADD/SUB take one
//          extra cycle in CORR for per-nibble BCD correction.
// Configuration macro: ALU_PIPE_DECIMAL_EN
//   defined   - decimal ADD/SUB supported (CORR state present)
//   undefined - dec is ignored, every mode has 1-cycle latency
// Ports:
//   clk   sole clock, rising edge
//   rst   synchronous active-low reset
//   bus   alu_pipe_if.slave (request fields, handshakes, result, flags)
// Parameter:
//   WIDTH datapath width, multiple of 4, minimum 8
module alu_pipe #(
   parameter int WIDTH = 8
) (
   input  logic       clk,
   input  logic       rst,
   alu_pipe_if.slave  bus
);

   localparam logic [2:0] MODE_ADD   = 3'd0;
   localparam logic [2:0] MODE_AND   = 3'd1;
   localparam logic [2:0] MODE_OR    = 3'd2;
   localparam logic [2:0] MODE_EOR   = 3'd3;
   localparam logic [2:0] MODE_SR    = 3'd4;
   localparam logic [2:0] MODE_SUB   = 3'd5;
   localparam logic [2:0] MODE_SL    = 3'd6;
   localparam logic [2:0] MODE_PASSB = 3'd7;

`ifdef ALU_PIPE_DECIMAL_EN
   localparam int NIBBLES = WIDTH / 4;
   typedef enum logic [1:0] {IDLE, CORR, DONE} state_t;
`else
   typedef enum logic [1:0] {IDLE, DONE} state_t;
`endif

   state_t state, state_n;

   logic             accept;
   logic             go_corr;

   // binary result computed straight from the request fields
   logic [WIDTH-1:0] b_eff;
   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] bin_res;
   logic             bin_c;
   logic             bin_v;

   // registered outputs
   logic [WIDTH-1:0] res_r;
   logic             carry_r;
   logic             ovf_r;
   logic             zero_r;
   logic             sign_r;

`ifdef ALU_PIPE_DECIMAL_EN
   // operands held for the correction cycle
   logic [WIDTH-1:0] lat_a;
   logic [WIDTH-1:0] lat_b;
   logic             lat_sub;
   logic             lat_cin;
   logic [WIDTH-1:0] dec_res;
   logic             dec_c;
`endif

   // ------------------------------------------------------------------
   // Handshake
   // ------------------------------------------------------------------
   // in_ready is gated by rst so nothing is accepted during a reset cycle.
   assign bus.in_ready  = rst && ((state == IDLE) ||
                                  ((state == DONE) && bus.out_ready));
   assign accept        = bus.in_valid && bus.in_ready;
   assign bus.out_valid = (state == DONE);

`ifdef ALU_PIPE_DECIMAL_EN
   assign go_corr = bus.dec && ((bus.mode == MODE_ADD) || (bus.mode == MODE_SUB));
`else
   logic unused_dec;
   assign unused_dec = bus.dec;
   assign go_corr    = 1'b0;
`endif

   // ------------------------------------------------------------------
   // Binary datapath
   // ------------------------------------------------------------------
   always_comb begin
      b_eff   = (bus.mode == MODE_SUB) ? ~bus.alu_b : bus.alu_b;
      sum     = {1'b0, bus.alu_a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, bus.carry_in};
      bin_res = '0;
      bin_c   = bus.carry_in;
      bin_v   = 1'b0;
      case (bus.mode)
         MODE_ADD, MODE_SUB: begin
            bin_res = sum[WIDTH-1:0];
            bin_c   = sum[WIDTH];
            // overflow: operands of equal sign giving a result of the other sign
            bin_v   = (bus.alu_a[WIDTH-1] == b_eff[WIDTH-1]) &&
                      (sum[WIDTH-1] != bus.alu_a[WIDTH-1]);
         end
         MODE_AND:   bin_res = bus.alu_a & bus.alu_b;
         MODE_OR:    bin_res = bus.alu_a | bus.alu_b;
         MODE_EOR:   bin_res = bus.alu_a ^ bus.alu_b;
         MODE_PASSB: bin_res = bus.alu_b;
         MODE_SR: begin
            bin_res = {bus.carry_in, bus.alu_a[WIDTH-1:1]};
            bin_c   = bus.alu_a[0];
         end
         MODE_SL: begin
            bin_res = {bus.alu_a[WIDTH-2:0], bus.carry_in};
            bin_c   = bus.alu_a[WIDTH-1];
         end
         default: begin
            bin_res = '0;
            bin_c   = bus.carry_in;
         end
      endcase
   end

`ifdef ALU_PIPE_DECIMAL_EN
   // ------------------------------------------------------------------
   // BCD correction, rippling nibble carries from the latched operands.
   // ADD: a nibble above 9 or one that carried gets +6 and carries out.
   // SUB: a nibble that borrowed gets -6 and borrows from the next one.
   // ------------------------------------------------------------------
   always_comb begin
      logic [4:0] nsum;
      logic       c;
      dec_res = '0;
      c       = lat_cin;
      nsum    = '0;
      for (int i = 0; i < NIBBLES; i++) begin
         if (lat_sub) begin
            nsum = {1'b0, lat_a[i*4 +: 4]} + {1'b0, ~lat_b[i*4 +: 4]} + {4'd0, c};
            c    = nsum[4];
            if (!c) begin
               nsum[3:0] = nsum[3:0] - 4'd6;
            end
         end else begin
            nsum = {1'b0, lat_a[i*4 +: 4]} + {1'b0, lat_b[i*4 +: 4]} + {4'd0, c};
            if (nsum > 5'd9) begin
               nsum = nsum + 5'd6;
               c    = 1'b1;
            end else begin
               c    = 1'b0;
            end
         end
         dec_res[i*4 +: 4] = nsum[3:0];
      end
      dec_c = c;
   end
`endif

   // ------------------------------------------------------------------
   // FSM next state
   // ------------------------------------------------------------------
   always_comb begin
      state_n = state;
      case (state)
         IDLE: begin
            if (accept) begin
`ifdef ALU_PIPE_DECIMAL_EN
               state_n = go_corr ? CORR : DONE;
`else
               state_n = DONE;
`endif
            end
         end
`ifdef ALU_PIPE_DECIMAL_EN
         CORR: state_n = DONE;
`endif
         DONE: begin
            if (bus.out_ready) begin
               if (accept) begin
`ifdef ALU_PIPE_DECIMAL_EN
                  state_n = go_corr ? CORR : DONE;
`else
                  state_n = DONE;
`endif
               end else begin
                  state_n = IDLE;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // State and result registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst) begin
         state   <= IDLE;
         res_r   <= '0;
         carry_r <= 1'b0;
         ovf_r   <= 1'b0;
         zero_r  <= 1'b0;
         sign_r  <= 1'b0;
`ifdef ALU_PIPE_DECIMAL_EN
         lat_a   <= '0;
         lat_b   <= '0;
         lat_sub <= 1'b0;
         lat_cin <= 1'b0;
`endif
      end else begin
         state <= state_n;
         if (accept) begin
            // result registers only change on acceptance (or in CORR),
            // so they hold while a result waits for out_ready
            res_r   <= bin_res;
            carry_r <= bin_c;
            ovf_r   <= bin_v;
            zero_r  <= (bin_res == '0);
            sign_r  <= bin_res[WIDTH-1];
`ifdef ALU_PIPE_DECIMAL_EN
            lat_a   <= bus.alu_a;
            lat_b   <= bus.alu_b;
            lat_sub <= (bus.mode == MODE_SUB);
            lat_cin <= bus.carry_in;
`endif
         end
`ifdef ALU_PIPE_DECIMAL_EN
         else if (state == CORR) begin
            // overflow keeps the binary value captured on acceptance
            res_r   <= dec_res;
            carry_r <= dec_c;
            zero_r  <= (dec_res == '0);
            sign_r  <= dec_res[WIDTH-1];
         end
`endif
      end
   end

   assign bus.alu_out   = res_r;
   assign bus.carry_out = carry_r;
   assign bus.overflow  = ovf_r;
   assign bus.zero      = zero_r;
   assign bus.sign      = sign_r;

endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - directed self-checking bench for alu_pipe
module tb_alu_pipe;

   logic clk;
   logic rst;
   int   total;
   int   bad;

   alu_pipe_if #(.WIDTH(8))  if8 ();
   alu_pipe_if #(.WIDTH(16)) if16 ();

   alu_pipe #(.WIDTH(8))  u_dut8  (.clk(clk), .rst(rst), .bus(if8));
   alu_pipe #(.WIDTH(16)) u_dut16 (.clk(clk), .rst(rst), .bus(if16));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic op8(input logic [2:0] m, input logic d, input logic [7:0] a,
                      input logic [7:0] b, input logic cin);
      if8.in_valid = 1'b1;
      if8.mode     = m;
      if8.dec      = d;
      if8.alu_a    = a;
      if8.alu_b    = b;
      if8.carry_in = cin;
   endtask

   task automatic flags8(input string tag, input logic [7:0] r, input logic c,
                         input logic v, input logic z, input logic n);
      chk({tag, "_valid"}, {31'd0, if8.out_valid}, 32'd1);
      chk({tag, "_out"},   {24'd0, if8.alu_out},   {24'd0, r});
      chk({tag, "_c"},     {31'd0, if8.carry_out}, {31'd0, c});
      chk({tag, "_v"},     {31'd0, if8.overflow},  {31'd0, v});
      chk({tag, "_z"},     {31'd0, if8.zero},      {31'd0, z});
      chk({tag, "_n"},     {31'd0, if8.sign},      {31'd0, n});
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst   = 1'b0;
      if8.in_valid  = 1'b0; if8.mode  = 3'd0; if8.dec  = 1'b0; if8.alu_a  = '0;
      if8.alu_b     = '0;   if8.carry_in  = 1'b0; if8.out_ready  = 1'b1;
      if16.in_valid = 1'b0; if16.mode = 3'd0; if16.dec = 1'b0; if16.alu_a = '0;
      if16.alu_b    = '0;   if16.carry_in = 1'b0; if16.out_ready = 1'b1;

      // reset state
      step(); step();
      chk("rst_valid", {31'd0, if8.out_valid}, 32'd0);
      chk("rst_out",   {24'd0, if8.alu_out},   32'd0);
      chk("rst_ready", {31'd0, if8.in_ready},  32'd0);
      chk("rst_flags", {28'd0, if8.carry_out, if8.overflow, if8.zero, if8.sign}, 32'd0);
      rst = 1'b1;
      #1;
      chk("idle_ready", {31'd0, if8.in_ready}, 32'd1);

      // ADD 0x50+0x50: signed overflow into negative
      op8(3'd0, 1'b0, 8'h50, 8'h50, 1'b0);
      step();
      flags8("add50", 8'hA0, 1'b0, 1'b1, 1'b0, 1'b1);

      // back-to-back: SUB 0x00-0x01 with no borrow in
      op8(3'd5, 1'b0, 8'h00, 8'h01, 1'b1);
      step();
      flags8("sub01", 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1);

      // SR 0x01, cin=1
      op8(3'd4, 1'b0, 8'h01, 8'h00, 1'b1);
      step();
      flags8("sr01", 8'h80, 1'b1, 1'b0, 1'b0, 1'b1);

      // SL 0x81, cin=0
      op8(3'd6, 1'b0, 8'h81, 8'h00, 1'b0);
      step();
      flags8("sl81", 8'h02, 1'b1, 1'b0, 1'b0, 1'b0);

      // AND passes carry_in through
      op8(3'd1, 1'b0, 8'hF0, 8'h3C, 1'b1);
      step();
      flags8("and", 8'h30, 1'b1, 1'b0, 1'b0, 1'b0);

      // EOR to zero
      op8(3'd3, 1'b0, 8'hFF, 8'hFF, 1'b0);
      step();
      flags8("eor", 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);

      // PASSB, dec ignored for non-arithmetic modes (1-cycle latency)
      op8(3'd7, 1'b1, 8'h12, 8'h7F, 1'b0);
      step();
      flags8("passb", 8'h7F, 1'b0, 1'b0, 1'b0, 1'b0);

      // SUB 0x80-0x01: signed overflow to positive, no borrow
      op8(3'd5, 1'b0, 8'h80, 8'h01, 1'b1);
      step();
      flags8("subov", 8'h7F, 1'b1, 1'b1, 1'b0, 1'b0);

      // stall: result held for 3 cycles, request ignored while not ready
      op8(3'd0, 1'b0, 8'h01, 8'h02, 1'b0);
      step();
      flags8("stall0", 8'h03, 1'b0, 1'b0, 1'b0, 1'b0);
      if8.out_ready = 1'b0;
      op8(3'd2, 1'b0, 8'h0F, 8'hF0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("stall_out",   {24'd0, if8.alu_out},   32'h03);
         chk("stall_valid", {31'd0, if8.out_valid}, 32'd1);
         chk("stall_ready", {31'd0, if8.in_ready},  32'd0);
         chk("stall_flags", {28'd0, if8.carry_out, if8.overflow, if8.zero, if8.sign}, 32'd0);
      end
      if8.out_ready = 1'b1;
      #1;
      chk("release_ready", {31'd0, if8.in_ready}, 32'd1);
      step();
      flags8("or_b2b", 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1);
      if8.in_valid = 1'b0;
      step();
      chk("drain_valid", {31'd0, if8.out_valid}, 32'd0);

      // decimal ADD 0x19+0x28
      op8(3'd0, 1'b1, 8'h19, 8'h28, 1'b0);
      step();
      if8.in_valid = 1'b0;
`ifdef ALU_PIPE_DECIMAL_EN
      chk("dec_corr_valid", {31'd0, if8.out_valid}, 32'd0);
      step();
      flags8("decadd", 8'h47, 1'b0, 1'b0, 1'b0, 1'b0);
      // decimal SUB 0x10-0x01
      op8(3'd5, 1'b1, 8'h10, 8'h01, 1'b1);
      step();
      if8.in_valid = 1'b0;
      chk("decsub_corr_valid", {31'd0, if8.out_valid}, 32'd0);
      step();
      flags8("decsub", 8'h09, 1'b1, 1'b0, 1'b0, 1'b0);
`else
      flags8("decadd", 8'h41, 1'b0, 1'b0, 1'b0, 1'b0);
`endif
      step();

      // reset while a result is pending in DONE
      if8.out_ready = 1'b0;
      op8(3'd0, 1'b0, 8'h55, 8'hAA, 1'b1);
      step();
      if8.in_valid = 1'b0;
      chk("pre_rst_valid", {31'd0, if8.out_valid}, 32'd1);
      rst = 1'b0;
      step();
      chk("rstd_valid", {31'd0, if8.out_valid}, 32'd0);
      chk("rstd_out",   {24'd0, if8.alu_out},   32'd0);
      chk("rstd_flags", {28'd0, if8.carry_out, if8.overflow, if8.zero, if8.sign}, 32'd0);
      chk("rstd_ready", {31'd0, if8.in_ready},  32'd0);
      rst = 1'b1;
      if8.out_ready = 1'b1;
      step();
      chk("post_rst_idle", {31'd0, if8.out_valid}, 32'd0);

`ifdef ALU_PIPE_DECIMAL_EN
      // reset while in CORR
      op8(3'd0, 1'b1, 8'h19, 8'h28, 1'b0);
      step();
      if8.in_valid = 1'b0;
      rst = 1'b0;
      step();
      chk("rstc_valid", {31'd0, if8.out_valid}, 32'd0);
      chk("rstc_out",   {24'd0, if8.alu_out},   32'd0);
      rst = 1'b1;
      step();
      chk("rstc_idle",  {31'd0, if8.out_valid}, 32'd0);
`endif

      // first op after reset release
      op8(3'd0, 1'b0, 8'h01, 8'h01, 1'b0);
      step();
      if8.in_valid = 1'b0;
      flags8("after_rst", 8'h02, 1'b0, 1'b0, 1'b0, 1'b0);

      // WIDTH=16 wrap to zero
      if16.in_valid = 1'b1;
      if16.mode     = 3'd0;
      if16.alu_a    = 16'hFFFF;
      if16.alu_b    = 16'h0001;
      if16.carry_in = 1'b0;
      step();
      if16.in_valid = 1'b0;
      chk("w16_valid", {31'd0, if16.out_valid}, 32'd1);
      chk("w16_out",   {16'd0, if16.alu_out},   32'h0000);
      chk("w16_z",     {31'd0, if16.zero},      32'd1);
      chk("w16_c",     {31'd0, if16.carry_out}, 32'd1);
      chk("w16_v",     {31'd0, if16.overflow},  32'd0);
      chk("w16_n",     {31'd0, if16.sign},      32'd0);

      // WIDTH=16 SL moves the top bit into carry
      if16.in_valid = 1'b1;
      if16.mode     = 3'd6;
      if16.alu_a    = 16'h8001;
      if16.carry_in = 1'b1;
      step();
      if16.in_valid = 1'b0;
      chk("w16sl_out", {16'd0, if16.alu_out},   32'h0003);
      chk("w16sl_c",   {31'd0, if16.carry_out}, 32'd1);
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
